// File: rtl/digital_clock_core.sv
// BCD 24-hour timekeeper with internal 1 Hz prescaler, validated time set and 12/24-hour display.
// Optional alarm is built when DIGITAL_CLOCK_ALARM_EN is defined.
module digital_clock_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int AUTO_OFF_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_12h,
  input  logic       set_stb,
  input  logic [1:0] set_hour_10,
  input  logic [3:0] set_hour_1,
  input  logic [2:0] set_min_10,
  input  logic [3:0] set_min_1,
  input  logic [2:0] set_sec_10,
  input  logic [3:0] set_sec_1,
  output logic       set_ok,
  output logic       set_err,
  output logic       tick_1hz,
  output logic [3:0] sec_1,
  output logic [2:0] sec_10,
  output logic [3:0] min_1,
  output logic [2:0] min_10,
  output logic [3:0] hour_1,
  output logic [1:0] hour_10,
  output logic       pm,
  input  logic       alarm_stb,
  input  logic [1:0] alarm_hour_10,
  input  logic [3:0] alarm_hour_1,
  input  logic [2:0] alarm_min_10,
  input  logic [3:0] alarm_min_1,
  input  logic       alarm_on,
  input  logic       alarm_ack,
  output logic       alarm_ring
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] r_pre;
  logic [3:0]    r_s1, r_m1, r_h1;
  logic [2:0]    r_s10, r_m10;
  logic [1:0]    r_h10;

  logic [3:0] w_n_s1, w_n_m1, w_n_h1, w_d_h1;
  logic [2:0] w_n_s10, w_n_m10;
  logic [1:0] w_n_h10, w_d_h10;
  logic [4:0] w_hbin, w_hsub;
  logic       w_set_valid, w_load, w_pre_last, w_tick;

  // set_stb is a single-cycle request with no back-pressure; exactly one of
  // set_ok / set_err answers it on the following cycle.
  assign w_set_valid = (set_hour_10 <= 2'd2) && (set_hour_1 <= 4'd9) &&
                       !((set_hour_10 == 2'd2) && (set_hour_1 > 4'd3)) &&
                       (set_min_10 <= 3'd5) && (set_sec_10 <= 3'd5) &&
                       (set_min_1 <= 4'd9) && (set_sec_1 <= 4'd9);
  assign w_load     = set_stb && w_set_valid;
  assign w_pre_last = (r_pre == PRE_MAX);
  assign w_tick     = w_pre_last && !w_load;

  always_comb begin
    w_n_s1 = r_s1; w_n_s10 = r_s10; w_n_m1 = r_m1;
    w_n_m10 = r_m10; w_n_h1 = r_h1; w_n_h10 = r_h10;
    if (w_load) begin
      w_n_s1 = set_sec_1; w_n_s10 = set_sec_10; w_n_m1 = set_min_1;
      w_n_m10 = set_min_10; w_n_h1 = set_hour_1; w_n_h10 = set_hour_10;
    end else if (w_tick) begin
      if (r_s1 != 4'd9) w_n_s1 = r_s1 + 4'd1;
      else begin
        w_n_s1 = 4'd0;
        if (r_s10 != 3'd5) w_n_s10 = r_s10 + 3'd1;
        else begin
          w_n_s10 = 3'd0;
          if (r_m1 != 4'd9) w_n_m1 = r_m1 + 4'd1;
          else begin
            w_n_m1 = 4'd0;
            if (r_m10 != 3'd5) w_n_m10 = r_m10 + 3'd1;
            else begin
              w_n_m10 = 3'd0;
              if ((r_h10 == 2'd2) && (r_h1 == 4'd3)) begin
                w_n_h10 = 2'd0; w_n_h1 = 4'd0;
              end else if (r_h1 == 4'd9) begin
                w_n_h10 = r_h10 + 2'd1; w_n_h1 = 4'd0;
              end else begin
                w_n_h1 = r_h1 + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Display is taken from the next-state time so digits move with tick_1hz/set_ok.
  assign w_hbin = 5'(w_n_h10) * 5'd10 + 5'(w_n_h1);
  assign w_hsub = w_hbin - 5'd12;

  always_comb begin
    w_d_h10 = w_n_h10;
    w_d_h1  = w_n_h1;
    if (mode_12h) begin
      if (w_hbin == 5'd0) begin
        w_d_h10 = 2'd1; w_d_h1 = 4'd2;
      end else if (w_hbin > 5'd12) begin
        if (w_hsub >= 5'd10) begin
          w_d_h10 = 2'd1; w_d_h1 = 4'(w_hsub - 5'd10);
        end else begin
          w_d_h10 = 2'd0; w_d_h1 = w_hsub[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_s1 <= '0; r_s10 <= '0; r_m1 <= '0; r_m10 <= '0; r_h1 <= '0; r_h10 <= '0;
      sec_1 <= '0; sec_10 <= '0; min_1 <= '0; min_10 <= '0; hour_1 <= '0; hour_10 <= '0;
      pm <= 1'b0; tick_1hz <= 1'b0; set_ok <= 1'b0; set_err <= 1'b0;
    end else begin
      r_pre <= (w_load || w_pre_last) ? '0 : r_pre + 1'b1;
      r_s1 <= w_n_s1; r_s10 <= w_n_s10; r_m1 <= w_n_m1;
      r_m10 <= w_n_m10; r_h1 <= w_n_h1; r_h10 <= w_n_h10;
      sec_1 <= w_n_s1; sec_10 <= w_n_s10; min_1 <= w_n_m1; min_10 <= w_n_m10;
      hour_1 <= w_d_h1; hour_10 <= w_d_h10;
      pm <= (w_hbin >= 5'd12);
      tick_1hz <= w_tick;
      set_ok <= w_load;
      set_err <= set_stb && !w_set_valid;
    end
  end

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic [1:0] r_al_h10;
  logic [3:0] r_al_h1, r_al_m1;
  logic [2:0] r_al_m10;
  logic       r_ring;
  logic [7:0] r_off_cnt;
  logic       w_al_valid, w_al_hit;

  assign w_al_valid = (alarm_hour_10 <= 2'd2) && (alarm_hour_1 <= 4'd9) &&
                      !((alarm_hour_10 == 2'd2) && (alarm_hour_1 > 4'd3)) &&
                      (alarm_min_10 <= 3'd5) && (alarm_min_1 <= 4'd9);
  // Only a tick can trigger; a set that lands on the alarm time never rings.
  assign w_al_hit = w_tick && alarm_on &&
                    (w_n_h10 == r_al_h10) && (w_n_h1 == r_al_h1) &&
                    (w_n_m10 == r_al_m10) && (w_n_m1 == r_al_m1) &&
                    (w_n_s10 == 3'd0) && (w_n_s1 == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_al_h10 <= '0; r_al_h1 <= '0; r_al_m10 <= '0; r_al_m1 <= '0;
      r_ring <= 1'b0; r_off_cnt <= '0;
    end else begin
      if (alarm_stb && w_al_valid) begin
        r_al_h10 <= alarm_hour_10; r_al_h1 <= alarm_hour_1;
        r_al_m10 <= alarm_min_10;  r_al_m1 <= alarm_min_1;
      end
      if (alarm_ack || !alarm_on) begin
        r_ring <= 1'b0;
      end else if (w_al_hit) begin
        r_ring <= 1'b1;
        r_off_cnt <= '0;
      end else if (r_ring && w_tick) begin
        if (r_off_cnt == 8'(AUTO_OFF_S - 1)) r_ring <= 1'b0;
        r_off_cnt <= r_off_cnt + 8'd1;
      end
    end
  end

  assign alarm_ring = r_ring;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_stb, alarm_hour_10, alarm_hour_1, alarm_min_10,
                            alarm_min_1, alarm_on, alarm_ack};
  assign alarm_ring = 1'b0;
`endif
endmodule

// File: tb/tb_digital_clock_core.sv
// Directed bench for digital_clock_core at CLK_HZ=4: table of set vectors plus
// hand sequences for reset, rollover, set/tick collision, invalid-set cadence and alarm.
module tb_digital_clock_core;
  logic       clk = 1'b0;
  logic       rst, mode_12h, set_stb;
  logic [1:0] set_hour_10;
  logic [3:0] set_hour_1, set_min_1, set_sec_1;
  logic [2:0] set_min_10, set_sec_10;
  logic       set_ok, set_err, tick_1hz, pm;
  logic [3:0] sec_1, min_1, hour_1;
  logic [2:0] sec_10, min_10;
  logic [1:0] hour_10;
  logic       alarm_stb, alarm_on, alarm_ack, alarm_ring;
  logic [1:0] alarm_hour_10;
  logic [3:0] alarm_hour_1, alarm_min_1;
  logic [2:0] alarm_min_10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digital_clock_core #(.CLK_HZ(4), .AUTO_OFF_S(60)) dut (
    .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_stb(set_stb),
    .set_hour_10(set_hour_10), .set_hour_1(set_hour_1), .set_min_10(set_min_10),
    .set_min_1(set_min_1), .set_sec_10(set_sec_10), .set_sec_1(set_sec_1),
    .set_ok(set_ok), .set_err(set_err), .tick_1hz(tick_1hz),
    .sec_1(sec_1), .sec_10(sec_10), .min_1(min_1), .min_10(min_10),
    .hour_1(hour_1), .hour_10(hour_10), .pm(pm),
    .alarm_stb(alarm_stb), .alarm_hour_10(alarm_hour_10), .alarm_hour_1(alarm_hour_1),
    .alarm_min_10(alarm_min_10), .alarm_min_1(alarm_min_1),
    .alarm_on(alarm_on), .alarm_ack(alarm_ack), .alarm_ring(alarm_ring)
  );

  typedef struct {
    logic        mode;
    logic [19:0] set_t;
    logic [19:0] exp_t;
    logic        exp_pm;
    logic        exp_ok;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [19:0] mk(input int h10, input int h1, input int m10,
                                     input int m1, input int s10, input int s1);
    return {2'(h10), 4'(h1), 3'(m10), 4'(m1), 3'(s10), 4'(s1)};
  endfunction

  function automatic logic [19:0] disp();
    return {hour_10, hour_1, min_10, min_1, sec_10, sec_1};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_set(input logic [19:0] t);
    {set_hour_10, set_hour_1, set_min_10, set_min_1, set_sec_10, set_sec_1} = t;
    set_stb = 1'b1;
    step();
    set_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode_12h = 1'b1; set_stb = 1'b0;
    {set_hour_10, set_hour_1, set_min_10, set_min_1, set_sec_10, set_sec_1} = '0;
    alarm_stb = 1'b0; alarm_on = 1'b0; alarm_ack = 1'b0;
    alarm_hour_10 = '0; alarm_hour_1 = '0; alarm_min_10 = '0; alarm_min_1 = '0;

    vecs[0]  = '{1'b0, mk(2,3,5,9,5,8),  mk(2,3,5,9,5,8), 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, mk(2,4,0,0,0,0),  mk(2,3,5,9,5,8), 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, mk(1,2,6,0,0,0),  mk(2,3,5,9,5,8), 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, mk(0,0,3,0,0,0),  mk(1,2,3,0,0,0), 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, mk(1,3,0,5,0,0),  mk(0,1,0,5,0,0), 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, mk(1,2,0,0,0,0),  mk(1,2,0,0,0,0), 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, mk(2,3,5,9,5,9),  mk(1,1,5,9,5,9), 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, mk(0,1,0,2,0,3),  mk(0,1,0,2,0,3), 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, mk(0,9,5,9,5,10), mk(0,1,0,2,0,3), 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, mk(1,10,0,0,0,0), mk(0,1,0,2,0,3), 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, mk(1,0,0,0,0,0),  mk(1,0,0,0,0,0), 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, mk(2,4,0,0,0,0),  mk(1,0,0,0,0,0), 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, mk(0,1,0,0,6,0),  mk(1,0,0,0,0,0), 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, mk(2,0,4,5,1,9),  mk(2,0,4,5,1,9), 1'b1, 1'b1, 1'b0};

    // Reset state and first tick after reset
    step(); step();
    chk("reset_digits", 32'(disp()), 32'h0);
    chk("reset_flags", {pm, tick_1hz, set_ok, set_err, alarm_ring}, 32'h0);
    rst = 1'b0;
    step();
    chk("post_reset_12h", 32'(disp()), 32'(mk(1,2,0,0,0,0)));
    chk("post_reset_pm", 32'(pm), 32'h0);
    step(); chk("first_tick_c2", 32'(tick_1hz), 32'h0);
    step(); chk("first_tick_c3", 32'(tick_1hz), 32'h0);
    step(); chk("first_tick_c4", 32'(tick_1hz), 32'h1);
    chk("first_tick_time", 32'(disp()), 32'(mk(1,2,0,0,0,1)));
    mode_12h = 1'b0;
    step();
    chk("mode_change_24h", 32'(disp()), 32'(mk(0,0,0,0,0,1)));

    // Table of set vectors
    for (int i = 0; i < 14; i++) begin
      mode_12h = vecs[i].mode;
      do_set(vecs[i].set_t);
      chk($sformatf("vec%0d_time", i), 32'(disp()), 32'(vecs[i].exp_t));
      chk($sformatf("vec%0d_pm", i), 32'(pm), 32'(vecs[i].exp_pm));
      chk($sformatf("vec%0d_ok_err", i), {set_ok, set_err}, {vecs[i].exp_ok, vecs[i].exp_err});
      chk($sformatf("vec%0d_tick", i), 32'(tick_1hz), 32'h0);
    end

    // Rollover 23:59:58 -> 23:59:59 -> 00:00:00
    mode_12h = 1'b0;
    do_set(mk(2,3,5,9,5,8));
    begin
      int ticks = 0;
      for (int c = 1; c <= 8; c++) begin
        step();
        if (tick_1hz) ticks++;
        if (c == 4) begin
          chk("roll_t1", 32'(disp()), 32'(mk(2,3,5,9,5,9)));
          chk("roll_pm1", 32'(pm), 32'h1);
        end
        if (c == 8) begin
          chk("roll_t2", 32'(disp()), 32'(mk(0,0,0,0,0,0)));
          chk("roll_pm0", 32'(pm), 32'h0);
        end
      end
      chk("roll_tick_count", 32'(ticks), 32'd2);
    end

    // Valid set on the prescaler wrap cycle
    do_set(mk(0,5,0,0,0,0));
    step(); step(); step();
    do_set(mk(1,0,0,0,0,0));
    chk("coll_ok", 32'(set_ok), 32'h1);
    chk("coll_no_tick", 32'(tick_1hz), 32'h0);
    chk("coll_time", 32'(disp()), 32'(mk(1,0,0,0,0,0)));
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("coll_hold%0d", c), {tick_1hz, disp()}, {1'b0, mk(1,0,0,0,0,0)});
    end
    step();
    chk("coll_next_sec", {tick_1hz, disp()}, {1'b1, mk(1,0,0,0,0,1)});

    // Invalid sets leave time and tick cadence alone
    do_set(mk(0,5,0,0,0,0));
    step();
    do_set(mk(2,4,0,0,0,0));
    chk("inv_err1", {set_err, set_ok}, 32'h2);
    do_set(mk(1,2,6,0,0,0));
    chk("inv_err2", {set_err, set_ok, disp()}, {2'b10, mk(0,5,0,0,0,0)});
    step();
    chk("inv_cadence", {tick_1hz, disp()}, {1'b1, mk(0,5,0,0,0,1)});

    // Reset mid-count at 12:34:56 with pre=2
    do_set(mk(1,2,3,4,5,6));
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_digits", 32'(disp()), 32'h0);
    chk("midrst_flags", {pm, tick_1hz, set_ok, set_err, alarm_ring}, 32'h0);
    step(); chk("midrst_c1", 32'(tick_1hz), 32'h0);
    step(); chk("midrst_c2", 32'(tick_1hz), 32'h0);
    step(); chk("midrst_c3", 32'(tick_1hz), 32'h0);
    step(); chk("midrst_c4", {tick_1hz, disp()}, {1'b1, mk(0,0,0,0,0,1)});

`ifdef DIGITAL_CLOCK_ALARM_EN
    alarm_on = 1'b1;
    {alarm_hour_10, alarm_hour_1, alarm_min_10, alarm_min_1} = {2'd0, 4'd7, 3'd0, 4'd0};
    alarm_stb = 1'b1;
    step();
    alarm_stb = 1'b0;
    do_set(mk(0,6,5,9,5,9));
    step(); step(); step(); step();
    chk("alarm_ring", {alarm_ring, disp()}, {1'b1, mk(0,7,0,0,0,0)});
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("alarm_ack_clear", 32'(alarm_ring), 32'h0);
    do_set(mk(0,6,5,9,5,9));
    step(); step(); step(); step();
    chk("alarm_ring2", 32'(alarm_ring), 32'h1);
    for (int k = 1; k <= 60; k++) begin
      step(); step(); step(); step();
      chk($sformatf("alarm_auto_t%0d", k), 32'(alarm_ring), (k < 60) ? 32'h1 : 32'h0);
    end
    do_set(mk(0,7,0,0,0,0));
    chk("alarm_set_no_ring", 32'(alarm_ring), 32'h0);
`else
    alarm_on = 1'b1;
    alarm_stb = 1'b1;
    step();
    alarm_stb = 1'b0;
    chk("alarm_tied_low", 32'(alarm_ring), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/digital_clock_core.md
# digital_clock_core

Parameterised BCD timekeeper that supersedes the fixed 1 Hz watch counter. It contains its own 1 Hz prescaler derived from the system clock, a validated time-set port, and selectable 12/24-hour display. An optional alarm can be compiled in. It drives the existing BCD digit inputs of the LCD string formatter directly and runs entirely in the `clk` domain.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency; one tick every `CLK_HZ` cycles; legal range ≥ 2.
- `AUTO_OFF_S`, 60: alarm auto-silence timeout in seconds (ALARM_EN only); legal range 1–255.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode_12h` in 1: 1 = 12-hour display, 0 = 24-hour; may change any cycle.
- `set_stb` in 1: one-cycle strobe; load the `set_*` fields.
- `set_hour_10` in 2, `set_hour_1` in 4, `set_min_10` in 3, `set_min_1` in 4, `set_sec_10` in 3, `set_sec_1` in 4: BCD time to load, always in 24-hour form.
- `set_ok` out 1: one-cycle pulse; set accepted.
- `set_err` out 1: one-cycle pulse; set rejected as invalid.
- `tick_1hz` out 1: one-cycle pulse on each second advance.
- `sec_1` out 4, `sec_10` out 3, `min_1` out 4, `min_10` out 3, `hour_1` out 4, `hour_10` out 2: registered display digits.
- `pm` out 1: 1 when the internal hour is 12–23. Valid in both display modes.
- `alarm_stb` in 1, `alarm_hour_10` in 2, `alarm_hour_1` in 4, `alarm_min_10` in 3, `alarm_min_1` in 4: load alarm time (24-hour BCD).
- `alarm_on` in 1: alarm arm enable.
- `alarm_ack` in 1: silence the ringing alarm.
- `alarm_ring` out 1: alarm active level.

## Operation
- **Prescaler.** Counter `pre` has width `$clog2(CLK_HZ)` and counts 0..`CLK_HZ`−1. The internal tick fires in the cycle where `pre == CLK_HZ-1`. `pre` then wraps to 0.
- **Time counters.** Internal time is kept as BCD in 24-hour form.
  - On tick: `sec_1` counts 0–9, carry into `sec_10` 0–5, carry into `min_1`, then `min_10` 0–5, then the hour.
  - Hour counts 00–23. 23:59:59 + tick gives 00:00:00.
  - All carries resolve in the same cycle as the tick.
- **Set validation.** A set is valid when all of the following hold:
  - `set_hour_10` ≤ 2.
  - `set_hour_1` ≤ 9, and ≤ 3 when `set_hour_10` = 2.
  - `set_min_10` ≤ 5 and `set_sec_10` ≤ 5.
  - `set_min_1` ≤ 9 and `set_sec_1` ≤ 9.
- **Valid set.** Time loads, `pre` clears to 0 so the next second is a full `CLK_HZ` cycles, and `set_ok` pulses.
- **Invalid set.** Time and `pre` are unchanged, and `set_err` pulses.
- **Set and tick in the same cycle.**
  - Valid set: the set wins, the tick is discarded, `tick_1hz` stays 0.
  - Invalid set: the tick proceeds normally.
- **Display conversion.** Outputs are registered from the internal time each cycle.
  - 24-hour mode: digits are passed through unchanged.
  - 12-hour mode, hour mapping:
    - Internal 00 displays 12.
    - 01–12 display unchanged.
    - 13–23 display hour − 12, in BCD; for example, 13 shows `hour_10`=0, `hour_1`=1.
  - Minutes and seconds are identical in both modes.

## Timing
- **Reset values.**
  - Internal time = 00:00:00 and `pre` = 0.
  - All outputs = 0: every digit, `pm`, `tick_1hz`, `set_ok`, `set_err` and `alarm_ring`.
- **First cycle after reset.** The displayed value is the converted time. In 12-hour mode this shows 12:00:00.
- **Tick latency.** The first tick after reset occurs `CLK_HZ` cycles after reset deasserts.
  - The tick cycle updates the internal time.
  - In the next cycle, `tick_1hz` is high and the digits show the new time.
  - Latency is 1 cycle, and it is identical for the set path.
- **Set latency.** `set_ok` and `set_err` assert 1 cycle after the `set_stb` cycle; the digits update in that same cycle.
- **Mode change.** A `mode_12h` change is reflected in the digits 1 cycle later. It has no effect on internal time.
- **Reset mid-operation.** Reset overrides set, tick and alarm, and clears all state in the next cycle.

## Configuration
- **`DIGITAL_CLOCK_ALARM_EN` defined.**
  - `alarm_stb` loads the alarm registers when the alarm fields are a valid HH:MM. An invalid alarm load is ignored.
  - `alarm_ring` sets in the cycle after a tick moves internal time to alarm HH:MM:00 while `alarm_on` = 1.
  - Once set, `alarm_ring` stays high until one of:
    - `alarm_ack` = 1 (clears in the next cycle);
    - `alarm_on` = 0;
    - `AUTO_OFF_S` ticks have elapsed.
  - A valid time set that lands exactly on the alarm time does not ring; only a tick can trigger the alarm.
  - Alarm registers reset to 00:00.
- **Macro not defined.**
  - No alarm logic is built.
  - `alarm_ring` is tied to 0.
  - All alarm inputs are ignored; the ports remain present.

## Test plan
- **Rollover:** `CLK_HZ`=4, 24-hour mode; set 23:59:58, run 8 cycles → two `tick_1hz` pulses; digits read 23:59:59, then 00:00:00; `pm` goes 1 → 0.
- **12-hour display:** set 00:30:00 with `mode_12h`=1 → shows 12:30:00, `pm`=0. Set 13:05:00 → shows 01:05:00, `pm`=1. Drop `mode_12h` → shows 13:05:00 one cycle later.
- **Invalid set:** set 24:00:00 and 12:60:00 → `set_err` pulses on each; time unchanged; tick cadence unbroken.
- **Set/tick collision:** `set_stb` with a valid 10:00:00 on the prescaler-wrap cycle → `set_ok`; no `tick_1hz`; 10:00:00 held for a full 4 cycles, then 10:00:01.
- **Alarm (ALARM_EN):**
  - Alarm 07:00, `alarm_on`=1; set 06:59:59; one tick → `alarm_ring`=1.
  - `alarm_ack` → ring clears next cycle.
  - Repeat without ack → ring clears after 60 ticks.
- **Reset mid-count:** assert `rst` for 1 cycle at 12:34:56 with `pre`=2 → next cycle all outputs 0; first tick exactly 4 cycles after `rst` deasserts.
